// File: rtl/mips_pkg.sv
// Shared constants and types for the multicycle MIPS control path:
// opcodes, ALUOp codes, state encodings and the decoded control bundle.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Encodings 12..15 are unreachable and decode to all-zero outputs.
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  function automatic logic is_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle control unit (master) and the
// datapath (slave): opcode in, all enables and mux selects out.
interface multicycle_control_if;
  logic [5:0] op;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       illegal_op;

  modport master (
    input  op,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op
  );

  modport slave (
    output op,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op
  );
endinterface

// File: rtl/multicycle_control_outdec.sv
// Moore output decoder: maps the control state to the datapath control bundle.
module multicycle_control_outdec
  import mips_pkg::*;
(
  input  state_e i_state,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.ir_write  = 1'b1;
        o_ctrl.alu_src_b = 2'b01;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.pc_write  = 1'b1;
      end
      DECODE: begin
        // Precompute the branch target while the opcode is decoded.
        o_ctrl.alu_src_b = 2'b11;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      MEMADR, ADDIEX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = 2'b10;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      MEMRD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      MEMWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.iord      = 1'b1;
      end
      EXECUTE: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = 2'b00;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      ALUWB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
      end
      BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = 2'b00;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = 2'b01;
      end
      JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = 2'b10;
      end
      ADDIWB: begin
        o_ctrl.reg_write = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control: state register, opcode-driven next-state
// logic and reset gating around the Moore output decoder.
module multicycle_control
  import mips_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  multicycle_control_if.master        bus
);

  state_e r_state;
  state_e w_next_state;
  state_e w_dec_state;
  ctrl_t  w_ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = FETCH;
    case (r_state)
      FETCH: w_next_state = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: w_next_state = MEMADR;
          OP_RTYPE:     w_next_state = EXECUTE;
          OP_BEQ:       w_next_state = BRANCH;
          OP_J:         w_next_state = JUMP;
          OP_ADDI:      w_next_state = ADDIEX;
          default:      w_next_state = FETCH;
        endcase
      end
      MEMADR:  w_next_state = (bus.op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   w_next_state = MEMWB;
      EXECUTE: w_next_state = ALUWB;
      ADDIEX:  w_next_state = ADDIWB;
      default: w_next_state = FETCH;
    endcase
  end

  // During reset the selects show FETCH values so the datapath is steady.
  assign w_dec_state = rst ? FETCH : r_state;

  multicycle_control_outdec u_outdec (
    .i_state (w_dec_state),
    .o_ctrl  (w_ctrl)
  );

  always_comb begin
    bus.PCWrite     = w_ctrl.pc_write      & ~rst;
    bus.PCWriteCond = w_ctrl.pc_write_cond & ~rst;
    bus.MemRead     = w_ctrl.mem_read      & ~rst;
    bus.MemWrite    = w_ctrl.mem_write     & ~rst;
    bus.IRWrite     = w_ctrl.ir_write      & ~rst;
    bus.RegWrite    = w_ctrl.reg_write     & ~rst;
    bus.IorD        = w_ctrl.iord;
    bus.MemtoReg    = w_ctrl.mem_to_reg;
    bus.RegDst      = w_ctrl.reg_dst;
    bus.ALUSrcA     = w_ctrl.alu_src_a;
    bus.ALUSrcB     = w_ctrl.alu_src_b;
    bus.ALUOp       = w_ctrl.alu_op;
    bus.PCSource    = w_ctrl.pc_source;
    bus.illegal_op  = ~rst && (r_state == DECODE) && !is_supported(bus.op);
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class
// cycle by cycle and compares the full control vector against hand values.
module tb_multicycle_control;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
  //  RegWrite,ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0],illegal_op}
  localparam logic [16:0] E_RESET  = 17'b0_0_0_0_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] E_FETCH  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] E_DECODE = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] E_DECILL = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [16:0] E_MEMADR = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] E_MEMRD  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] E_MEMWB  = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] E_MEMWR  = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] E_EXEC   = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] E_ALUWB  = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] E_BRANCH = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] E_JUMP   = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
  localparam logic [16:0] E_ADDIWB = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

  localparam logic [5:0] O_R    = 6'b000000;
  localparam logic [5:0] O_LW   = 6'b100011;
  localparam logic [5:0] O_SW   = 6'b101011;
  localparam logic [5:0] O_BEQ  = 6'b000100;
  localparam logic [5:0] O_J    = 6'b000010;
  localparam logic [5:0] O_ADDI = 6'b001000;
  localparam logic [5:0] O_BAD  = 6'b111111;

  function automatic logic [16:0] observed();
    return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
            bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
            bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.illegal_op};
  endfunction

  // Apply inputs for one cycle, compare mid-cycle, then advance past the edge.
  task automatic cyc(input logic [5:0] o, input logic r, input logic [16:0] exp,
                     input string tag);
    logic [16:0] obs;
    bus.op = o;
    rst    = r;
    #2;
    obs = observed();
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.op   = O_R;
    @(posedge clk);
    #1;
    cyc(O_R, 1'b1, E_RESET, "reset_hold");

    // lw: five cycles
    cyc(O_LW, 1'b0, E_FETCH,  "lw_fetch");
    cyc(O_LW, 1'b0, E_DECODE, "lw_decode");
    cyc(O_LW, 1'b0, E_MEMADR, "lw_memadr");
    cyc(O_LW, 1'b0, E_MEMRD,  "lw_memrd");
    cyc(O_LW, 1'b0, E_MEMWB,  "lw_memwb");

    // R-type
    cyc(O_R, 1'b0, E_FETCH,  "r_fetch");
    cyc(O_R, 1'b0, E_DECODE, "r_decode");
    cyc(O_R, 1'b0, E_EXEC,   "r_execute");
    cyc(O_R, 1'b0, E_ALUWB,  "r_aluwb");

    // beq with a junk opcode during FETCH, which must be ignored
    cyc(O_BAD, 1'b0, E_FETCH,  "beq_fetch");
    cyc(O_BEQ, 1'b0, E_DECODE, "beq_decode");
    cyc(O_BEQ, 1'b0, E_BRANCH, "beq_branch");

    // sw then j back-to-back, seven cycles
    cyc(O_SW, 1'b0, E_FETCH,  "sw_fetch");
    cyc(O_SW, 1'b0, E_DECODE, "sw_decode");
    cyc(O_SW, 1'b0, E_MEMADR, "sw_memadr");
    cyc(O_SW, 1'b0, E_MEMWR,  "sw_memwr");
    cyc(O_J,  1'b0, E_FETCH,  "j_fetch");
    cyc(O_J,  1'b0, E_DECODE, "j_decode");
    cyc(O_J,  1'b0, E_JUMP,   "j_jump");

    // addi
    cyc(O_ADDI, 1'b0, E_FETCH,  "addi_fetch");
    cyc(O_ADDI, 1'b0, E_DECODE, "addi_decode");
    cyc(O_ADDI, 1'b0, E_MEMADR, "addi_ex");
    cyc(O_ADDI, 1'b0, E_ADDIWB, "addi_wb");

    // lw with opcode changing after MEMADR: sequence must be unaffected
    cyc(O_LW,  1'b0, E_FETCH,  "lw2_fetch");
    cyc(O_LW,  1'b0, E_DECODE, "lw2_decode");
    cyc(O_LW,  1'b0, E_MEMADR, "lw2_memadr");
    cyc(O_SW,  1'b0, E_MEMRD,  "lw2_memrd_opchg");
    cyc(O_BAD, 1'b0, E_MEMWB,  "lw2_memwb_opchg");

    // reset asserted while in MEMRD
    cyc(O_LW, 1'b0, E_FETCH,  "rstmid_fetch");
    cyc(O_LW, 1'b0, E_DECODE, "rstmid_decode");
    cyc(O_LW, 1'b0, E_MEMADR, "rstmid_memadr");
    cyc(O_LW, 1'b1, E_RESET,  "rstmid_in_memrd");
    cyc(O_LW, 1'b0, E_FETCH,  "rstmid_after");
    cyc(O_LW, 1'b0, E_DECODE, "rstmid_decode2");
    cyc(O_LW, 1'b0, E_MEMADR, "rstmid_memadr2");

    // illegal opcode: finish the lw first, then two-cycle illegal
    cyc(O_LW,  1'b0, E_MEMRD,  "pre_ill_memrd");
    cyc(O_LW,  1'b0, E_MEMWB,  "pre_ill_memwb");
    cyc(O_BAD, 1'b0, E_FETCH,  "ill_fetch");
    cyc(O_BAD, 1'b0, E_DECILL, "ill_decode");
    cyc(O_BAD, 1'b0, E_FETCH,  "ill_refetch");
    cyc(O_BAD, 1'b0, E_DECILL, "ill_decode2");
    cyc(O_R,   1'b0, E_FETCH,  "ill_final_fetch");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
